jelly_ring_bus_crossbar_rx_fifo: RTL and testbench



---
 rtl/jelly_ring_bus_crossbar_rx_fifo_ram.sv | 74 +++++++
 rtl/jelly_ring_bus_crossbar_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_jelly_ring_bus_crossbar_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jelly_ring_bus_crossbar_rx_fifo_ram.sv
// ---------------------------------------------------------------------------
// jelly_ring_bus_crossbar_rx_fifo_ram
//
// Purpose:
//   Simple dual-port RAM holding the words queued behind the output stage of
//   the crossbar receive FIFO. One write port, one synchronous read port.
//   The read data register holds its value while rd_en_i is low, so the
//   FIFO can use it directly as part of its output stage.
//
// Parameters:
//   WIDTH      word width
//   ADDR_WIDTH address width, depth = 2**ADDR_WIDTH
//   RAM_TYPE   "distributed" (LUT RAM) or "block" (block RAM) storage hint
//
// Ports:
//   clk        clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe, updates rd_data_o on the next edge
//   rd_addr_i  read address
//   rd_data_o  registered read data
// ---------------------------------------------------------------------------
module jelly_ring_bus_crossbar_rx_fifo_ram #(
    parameter int WIDTH      = 35,
    parameter int ADDR_WIDTH = 4,
    parameter     RAM_TYPE   = "distributed"
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (RAM_TYPE == "block") begin : g_block
            (* ram_style = "block" *)
            logic [WIDTH-1:0] mem_q [0:DEPTH-1];
            logic [WIDTH-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (wr_en_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
                if (rd_en_i) begin
                    rd_data_q <= mem_q[rd_addr_i];
                end
            end

            assign rd_data_o = rd_data_q;
        end else begin : g_distributed
            (* ram_style = "distributed" *)
            logic [WIDTH-1:0] mem_q [0:DEPTH-1];
            logic [WIDTH-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (wr_en_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
                if (rd_en_i) begin
                    rd_data_q <= mem_q[rd_addr_i];
                end
            end

            assign rd_data_o = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/jelly_ring_bus_crossbar_rx_fifo.sv
// ---------------------------------------------------------------------------
// jelly_ring_bus_crossbar_rx_fifo
//
// Purpose:
//   Receive-side buffer downstream of one crossbar master port. Stores
//   {id_from, data} words and presents them through a registered valid/ready
//   output stage. Total capacity DEPTH = 2**PTR_WIDTH words, counting the RAM
//   and the output stage together.
//
// Handshake: a transfer happens on a clock edge where cke is high and both
//   valid and ready are high. valid must not depend on ready; s_ready is a
//   pure register (no combinational path from m_ready), and m_* hold steady
//   while m_valid is high and m_ready is low.
//
// Optional feature (macro JELLY_RING_BUS_CROSSBAR_RX_FIFO_STATS_EN):
//   adds stat_clear input and the saturating counters stat_words (accepted
//   writes) and stat_full_cycles (cycles with cke && s_valid && !s_ready).
//
// Ports:
//   clk, reset, cke           clock, sync active-high reset, clock enable
//   s_id_from, s_data,        input word and its valid/ready
//   s_valid, s_ready
//   m_id_from, m_data,        head word and its valid/ready
//   m_valid, m_ready
//   level                     words held, 0..DEPTH
//   almost_full               level >= ALMOST_FULL_TH
// ---------------------------------------------------------------------------
module jelly_ring_bus_crossbar_rx_fifo #(
    parameter int S_ID_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int PTR_WIDTH      = 4,
    parameter int ALMOST_FULL_TH = 12,
    parameter     RAM_TYPE       = "distributed"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,

    input  logic [S_ID_WIDTH-1:0] s_id_from,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic [S_ID_WIDTH-1:0] m_id_from,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,

`ifdef JELLY_RING_BUS_CROSSBAR_RX_FIFO_STATS_EN
    input  logic                  stat_clear,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_full_cycles,
`endif

    output logic [PTR_WIDTH:0]    level,
    output logic                  almost_full
);

    localparam int                WIDTH   = S_ID_WIDTH + DATA_WIDTH;
    localparam int                DEPTH   = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_L = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_TH_L = (PTR_WIDTH+1)'(ALMOST_FULL_TH);

    logic [PTR_WIDTH:0]   level_q, level_d;
    logic                 s_ready_q;
    logic                 m_valid_q, m_valid_d;
    logic                 almost_full_q;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    // sel_q: 1 = head word is in the RAM read register, 0 = in byp_q
    logic                 sel_q, sel_d;
    logic [WIDTH-1:0]     byp_q;
    logic [WIDTH-1:0]     ram_rd_data;

    logic wr_en;
    logic rd_en;
    logic ram_has;
    logic load;
    logic ram_rd;
    logic bypass;
    logic ram_wr;

    assign wr_en = cke && s_valid && s_ready_q;
    assign rd_en = cke && m_valid_q && m_ready;

    // Words sitting in the RAM = level minus the one in the output stage.
    // Whenever the RAM holds anything the output stage is also occupied.
    assign ram_has = (level_q > {{PTR_WIDTH{1'b0}}, m_valid_q});

    // The output stage is free after this edge: empty now or being consumed.
    assign load   = cke && (!m_valid_q || m_ready);
    assign ram_rd = load && ram_has;
    // With an empty RAM the incoming word skips the RAM so it shows up on
    // m_* one cycle after it was written.
    assign bypass = load && !ram_has && wr_en;
    assign ram_wr = wr_en && !bypass;

    always_comb begin
        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            level_d = level_q - 1'b1;
        end

        m_valid_d = m_valid_q;
        if (load) begin
            m_valid_d = ram_has || wr_en;
        end

        sel_d = sel_q;
        if (ram_rd) begin
            sel_d = 1'b1;
        end else if (bypass) begin
            sel_d = 1'b0;
        end

        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(ram_wr);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(ram_rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q       <= '0;
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            almost_full_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sel_q         <= 1'b0;
        end else if (cke) begin
            level_q       <= level_d;
            s_ready_q     <= (level_d < DEPTH_L);
            m_valid_q     <= m_valid_d;
            almost_full_q <= (level_d >= AF_TH_L);
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            sel_q         <= sel_d;
        end
    end

    // Bypass holding register: contents are don't-care while not selected.
    always_ff @(posedge clk) begin
        if (bypass) begin
            byp_q <= {s_id_from, s_data};
        end
    end

    jelly_ring_bus_crossbar_rx_fifo_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (PTR_WIDTH),
        .RAM_TYPE   (RAM_TYPE)
    ) u_ram (
        .clk        (clk),
        .wr_en_i    (ram_wr),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  ({s_id_from, s_data}),
        .rd_en_i    (ram_rd),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (ram_rd_data)
    );

    assign {m_id_from, m_data} = sel_q ? ram_rd_data : byp_q;
    assign m_valid     = m_valid_q;
    assign s_ready     = s_ready_q;
    assign level       = level_q;
    assign almost_full = almost_full_q;

`ifdef JELLY_RING_BUS_CROSSBAR_RX_FIFO_STATS_EN
    logic [31:0] stat_words_q;
    logic [31:0] stat_full_cycles_q;

    always_ff @(posedge clk) begin
        if (reset || stat_clear) begin
            stat_words_q       <= '0;
            stat_full_cycles_q <= '0;
        end else begin
            if (wr_en && (stat_words_q != 32'hFFFF_FFFF)) begin
                stat_words_q <= stat_words_q + 32'd1;
            end
            if (cke && s_valid && !s_ready_q && (stat_full_cycles_q != 32'hFFFF_FFFF)) begin
                stat_full_cycles_q <= stat_full_cycles_q + 32'd1;
            end
        end
    end

    assign stat_words       = stat_words_q;
    assign stat_full_cycles = stat_full_cycles_q;
`endif

endmodule

// File: tb/tb_jelly_ring_bus_crossbar_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_jelly_ring_bus_crossbar_rx_fifo
//
// Directed bench for the crossbar receive FIFO. The driver pushes every
// accepted word into exp_q; a negedge monitor checks level/flags against the
// queue size and compares the head word, popping on each read.
// ---------------------------------------------------------------------------
module tb_jelly_ring_bus_crossbar_rx_fifo;

    localparam int S_ID_WIDTH = 3;
    localparam int DATA_WIDTH = 32;
    localparam int PTR_WIDTH  = 4;
    localparam int W          = S_ID_WIDTH + DATA_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset   = 1'b1;
    logic                  cke     = 1'b1;
    logic [S_ID_WIDTH-1:0] s_id_from = '0;
    logic [DATA_WIDTH-1:0] s_data    = '0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [S_ID_WIDTH-1:0] m_id_from;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [PTR_WIDTH:0]    level;
    logic                  almost_full;
`ifdef JELLY_RING_BUS_CROSSBAR_RX_FIFO_STATS_EN
    logic                  stat_clear = 1'b0;
    logic [31:0]           stat_words;
    logic [31:0]           stat_full_cycles;
`endif

    jelly_ring_bus_crossbar_rx_fifo #(
        .S_ID_WIDTH     (S_ID_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .PTR_WIDTH      (PTR_WIDTH),
        .ALMOST_FULL_TH (12),
        .RAM_TYPE       ("distributed")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .s_id_from   (s_id_from),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_id_from   (m_id_from),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
`ifdef JELLY_RING_BUS_CROSSBAR_RX_FIFO_STATS_EN
        .stat_clear       (stat_clear),
        .stat_words       (stat_words),
        .stat_full_cycles (stat_full_cycles),
`endif
        .level       (level),
        .almost_full (almost_full)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic rst_smp = 1'b0;
    logic rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_smp <= reset;

    // Monitor: runs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_smp) begin
            exp_q.delete();
            chk("rst_level", 64'(level), 64'd0);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_almost_full", 64'(almost_full), 64'd0);
        end else if (!reset) begin
            chk("level", 64'(level), 64'(exp_q.size()));
            chk("almost_full", 64'(almost_full), 64'(exp_q.size() >= 12));
            chk("s_ready", 64'(s_ready), 64'(exp_q.size() < 16));
            chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
            if (m_valid && exp_q.size() != 0) begin
                chk("head_word", 64'({m_id_from, m_data}), 64'(exp_q[0]));
                if (cke && m_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock: decide acceptance at the negedge, record it at the posedge,
    // return 1 time unit after the posedge.
    task automatic step(output logic acc);
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = !reset && cke && s_valid && s_ready;
        @(posedge clk);
        if (acc) exp_q.push_back({s_id_from, s_data});
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic drive_word(input logic [S_ID_WIDTH-1:0] id, input logic [DATA_WIDTH-1:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        s_id_from = id;
        s_data    = d;
        s_valid   = 1'b1;
        while (!acc && n < 200) begin
            step(acc);
            n++;
        end
        if (!acc) chk("drive_timeout", 64'd0, 64'd1);
        s_valid   = 1'b0;
        s_id_from = 'x;
        s_data    = 'x;
    endtask

    task automatic drain(input string name, input int bound);
        logic acc;
        int   n;
        n = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            step(acc);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_now(input string name, input int lvl, input logic srdy, input logic af);
        chk({name, "_level"}, 64'(level), 64'(lvl));
        chk({name, "_s_ready"}, 64'(s_ready), 64'(srdy));
        chk({name, "_almost_full"}, 64'(almost_full), 64'(af));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic acc;

        // Reset
        reset = 1'b1;
        idle(3);
        check_now("in_reset", 0, 1'b0, 1'b0);
        chk("in_reset_m_valid", 64'(m_valid), 64'd0);
        reset = 1'b0;
        idle(1);
        check_now("post_reset", 0, 1'b1, 1'b0);

        // Single word through an empty buffer
        m_ready = 1'b1;
        drive_word(3'd3, 32'hA5A5_0001);
        check_now("single_wr", 1, 1'b1, 1'b0);
        chk("single_m_valid", 64'(m_valid), 64'd1);
        chk("single_id", 64'(m_id_from), 64'd3);
        chk("single_data", 64'(m_data), 64'hA5A5_0001);
        idle(1);
        check_now("single_rd", 0, 1'b1, 1'b0);
        chk("single_pops", 64'(pops), 64'd1);

        // Fill to DEPTH with the consumer stalled
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_word(3'(i % 8), 32'(i));
            check_now("fill", i + 1, (i + 1) < 16, (i + 1) >= 12);
        end
        chk("full_head", 64'(m_data), 64'd0);

        // Read at level 16 with a word offered: no write that cycle
        s_id_from = 3'd1;
        s_data    = 32'd100;
        s_valid   = 1'b1;
        m_ready   = 1'b1;
        step(acc);
        chk("full_no_accept", 64'(acc), 64'd0);
        check_now("full_read", 15, 1'b1, 1'b1);
        chk("full_read_head", 64'(m_data), 64'd1);

        // Simultaneous read and write at level 15
        for (int k = 0; k < 3; k++) begin
            s_data = 32'(100 + k);
            step(acc);
            chk("rw15_accept", 64'(acc), 64'd1);
            check_now("rw15", 15, 1'b1, 1'b1);
        end
        s_valid = 1'b0;
        drain("fill_drain", 40);
        check_now("fill_empty", 0, 1'b1, 1'b0);
        chk("fill_pops", 64'(pops), 64'd20);

        // Clock enable low freezes everything
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_word(3'(7 - i), 32'(200 + i));
        check_now("cke_pre", 4, 1'b1, 1'b0);
        cke       = 1'b0;
        s_valid   = 1'b1;
        s_id_from = 3'd5;
        s_data    = 32'd300;
        m_ready   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            check_now("cke_hold", 4, 1'b1, 1'b0);
            chk("cke_hold_data", 64'(m_data), 64'd200);
            chk("cke_hold_valid", 64'(m_valid), 64'd1);
        end
        cke     = 1'b1;
        s_valid = 1'b0;
        drain("cke_drain", 40);
        chk("cke_pops", 64'(pops), 64'd24);

        // Reset in the middle of operation at level 9
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) drive_word(3'(i % 8), 32'(400 + i));
        check_now("pre_flush", 9, 1'b1, 1'b0);
        reset = 1'b1;
        idle(1);
        check_now("flush", 0, 1'b0, 1'b0);
        chk("flush_m_valid", 64'(m_valid), 64'd0);
        reset = 1'b0;
        idle(1);
        check_now("flush_release", 0, 1'b1, 1'b0);
        m_ready = 1'b1;
        drive_word(3'd2, 32'd500);
        chk("flush_first_data", 64'(m_data), 64'd500);
        chk("flush_first_id", 64'(m_id_from), 64'd2);
        drive_word(3'd4, 32'd501);
        drive_word(3'd6, 32'd502);
        drain("flush_drain", 40);
        chk("flush_pops", 64'(pops), 64'd27);

        // Long stream with gaps and random consumer stalls (pointer wrap)
        rnd_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            idle($urandom_range(0, 2));
            drive_word(3'(i % 8), 32'(1000 + i));
        end
        rnd_rdy = 1'b0;
        drain("wrap_drain", 200);
        chk("wrap_pops", 64'(pops), 64'd127);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound on the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
